ppe_grant_ctrl: RTL

- Round-robin grant controller that sits on the consumer side of the 1024-wide programmable priority encoder (PPE).
- Owns the pending-request bitmap and drives it onto the PPE `Req` input, and drives the priority pointer onto `P_enc`.
- Captures the PPE result (`o_value`, `valid`) into a registered valid/ready grant, decodes it back to one-hot, and retires that request.
- On each accepted grant the pointer moves to grant+1, which gives round-robin fairness.

---
 rtl/ppe_grant_ctrl_if.sv | 38 +++
 rtl/ppe_grant_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/ppe_grant_ctrl_if.sv
// rtl/ppe_grant_ctrl_if.sv - grant controller bundle: request set, PPE link and grant handshake
//
// Purpose: groups every non-clock/reset signal of ppe_grant_ctrl.
// Signals:
//   set_vld/set_idx    new request arrival
//   clr_all            flush of all pending requests
//   Req/P_enc          pending bitmap and priority pointer towards the PPE
//   ppe_value/ppe_valid PPE result (combinational from Req/P_enc)
//   gnt_vld/gnt_idx/gnt_onehot/gnt_rdy  registered grant handshake
//   pend_cnt           popcount of Req
// Modports: master = controller side, slave = environment side.
interface ppe_grant_ctrl_if #(
  parameter int WIDTH = 1024,
  parameter int IDX_W = 10
);
  logic             set_vld;
  logic [IDX_W-1:0] set_idx;
  logic             clr_all;
  logic [WIDTH-1:0] Req;
  logic [IDX_W-1:0] P_enc;
  logic [IDX_W-1:0] ppe_value;
  logic             ppe_valid;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_onehot;
  logic             gnt_rdy;
  logic [IDX_W:0]   pend_cnt;

  modport master (
    input  set_vld, set_idx, clr_all, ppe_value, ppe_valid, gnt_rdy,
    output Req, P_enc, gnt_vld, gnt_idx, gnt_onehot, pend_cnt
  );

  modport slave (
    output set_vld, set_idx, clr_all, ppe_value, ppe_valid, gnt_rdy,
    input  Req, P_enc, gnt_vld, gnt_idx, gnt_onehot, pend_cnt
  );
endinterface

// File: rtl/ppe_grant_ctrl.sv
// rtl/ppe_grant_ctrl.sv - round-robin grant controller on the consumer side of the PPE
//
// Purpose: owns the pending-request bitmap and priority pointer driven into
// the programmable priority encoder, captures its result as a registered
// valid/ready grant, and retires the granted request on acceptance. The
// pointer moves to grant+1 on every accepted grant, giving round-robin order.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    ppe_grant_ctrl_if.master (request set, flush, PPE link, grant handshake)
// WIDTH must equal 2**IDX_W so the pointer increment wraps naturally.
module ppe_grant_ctrl #(
  parameter int WIDTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  ppe_grant_ctrl_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] req_q, req_nxt;
  logic [WIDTH-1:0] onehot_q, onehot_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_nxt;
  logic [IDX_W-1:0] gidx_q, gidx_nxt;
  logic [IDX_W:0]   cnt_q, cnt_nxt;
  logic             accept;
  logic             set_new;
  logic             retire;

  always_comb begin
    state_nxt  = state;
    req_nxt    = req_q;
    onehot_nxt = onehot_q;
    ptr_nxt    = ptr_q;
    gidx_nxt   = gidx_q;
    cnt_nxt    = cnt_q;

    accept  = (state == HOLD) && bus.gnt_rdy;
    // Only a bit that was clear counts as a new arrival.
    set_new = bus.set_vld && !req_q[bus.set_idx];
    // A same-cycle set of the granted index re-arms it, so nothing retires.
    retire  = accept && !(bus.set_vld && (bus.set_idx == gidx_q));

    case (state)
      IDLE: begin
        if (bus.ppe_valid) begin
          state_nxt                = HOLD;
          gidx_nxt                 = bus.ppe_value;
          onehot_nxt               = '0;
          onehot_nxt[bus.ppe_value] = 1'b1;
        end
      end
      HOLD: begin
        if (bus.gnt_rdy) begin
          state_nxt       = IDLE;
          onehot_nxt      = '0;
          ptr_nxt         = gidx_q + 1'b1;
          req_nxt[gidx_q] = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Applied after the retire so a set of the same index wins.
    if (bus.set_vld) begin
      req_nxt[bus.set_idx] = 1'b1;
    end

    case ({set_new, retire})
      2'b10:   cnt_nxt = cnt_q + 1'b1;
      2'b01:   cnt_nxt = cnt_q - 1'b1;
      default: cnt_nxt = cnt_q;
    endcase

    // Flush beats both arrival and acceptance; the pointer is left alone.
    if (bus.clr_all) begin
      state_nxt  = IDLE;
      req_nxt    = '0;
      onehot_nxt = '0;
      cnt_nxt    = '0;
      ptr_nxt    = ptr_q;
      gidx_nxt   = gidx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      req_q    <= req_nxt;
      onehot_q <= onehot_nxt;
      ptr_q    <= ptr_nxt;
      gidx_q   <= gidx_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  assign bus.Req        = req_q;
  assign bus.P_enc      = ptr_q;
  assign bus.gnt_vld    = (state == HOLD);
  assign bus.gnt_idx    = gidx_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.pend_cnt   = cnt_q;

endmodule
